l1_cache_ctrl: RTL and testbench

- Sequencing controller that sits between the CPU data port, the L1 n-way data cache and the main-memory word port.
- Read hits are served combinationally from the cache.
- Read misses trigger a word-by-word line fetch from memory, followed by a one-cycle block fill into the cache.
- All writes are write-through, no write-allocate. The CPU is stalled until each write is acknowledged by memory.
- Keeps wrap-around hit/miss performance counters.

---
 rtl/l1_cache_ctrl_pkg.sv | 21 ++
 rtl/l1_line_buffer.sv | 48 ++++
 rtl/l1_cache_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_l1_cache_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_cache_ctrl_pkg.sv
// l1_cache_ctrl_pkg
//   Shared types and line-geometry constants for the L1 cache controller.
//   The geometry constants are derived from the default 32-bit word and
//   16-byte line, which is the geometry the controller is built for.
package l1_cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    FILL    = 2'd2,
    INSTALL = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_LINE_SIZE  = 16;
  localparam int WORDS_PER_LINE     = DEFAULT_LINE_SIZE / (DEFAULT_DATA_WIDTH / 8);
  localparam int WORD_SEL_BITS      = $clog2(WORDS_PER_LINE);
  localparam int OFFSET_BITS        = $clog2(DEFAULT_LINE_SIZE);
  localparam int BYTE_SEL_BITS      = OFFSET_BITS - WORD_SEL_BITS;

endpackage

// File: rtl/l1_line_buffer.sv
// l1_line_buffer
//   Assembles one cache line from successive memory words.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     clear     : restart assembly at word 0 (line contents are kept)
//     load      : store data into the current word slot and advance
//     data      : incoming memory word
//     word_sel  : index of the word slot that the next load will fill
//     line      : assembled line, word i at bits [DATA_WIDTH*i +: DATA_WIDTH]
//     last      : current slot is the final word of the line
module l1_line_buffer
  import l1_cache_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 load,
  input  logic [DATA_WIDTH-1:0]                data,
  output logic [WORD_SEL_BITS-1:0]             word_sel,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] line,
  output logic                                 last
);

  logic [WORD_SEL_BITS-1:0]             word_sel_r;
  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] line_r;

  // Word counter and line assembly register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_sel_r <= {WORD_SEL_BITS{1'b0}};
      line_r     <= {(DATA_WIDTH*WORDS_PER_LINE){1'b0}};
    end else if (clear) begin
      word_sel_r <= {WORD_SEL_BITS{1'b0}};
    end else if (load) begin
      line_r[word_sel_r*DATA_WIDTH +: DATA_WIDTH] <= data;
      word_sel_r <= word_sel_r + {{(WORD_SEL_BITS-1){1'b0}}, 1'b1};
    end else begin
      word_sel_r <= word_sel_r;
    end
  end

  assign word_sel = word_sel_r;
  assign line     = line_r;
  assign last     = (word_sel_r == WORD_SEL_BITS'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl
//   Sequences CPU accesses between the L1 data cache and main memory.
//   Read hits complete combinationally; read misses fetch the line word by
//   word, install it in one cycle, then replay the read as a hit. Writes are
//   write-through without allocation and stall until memory acknowledges.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     cpu_*               : CPU request (valid/we/addr/w_data), r_data, stall
//     cache_*             : forwarded access to the cache, hit/r_data back
//     fill_*              : one-cycle line install (en/addr/data/mark_valid)
//     mem_*               : memory word port (req/we/addr/w_data, ack/r_data)
//     hit_count/miss_count: wrap-around read hit/miss counters
module l1_cache_ctrl
  import l1_cache_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_valid,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0]  cpu_w_data,
  output logic [DATA_WIDTH-1:0]  cpu_r_data,
  output logic                   cpu_stall,
  output logic                   cache_valid,
  output logic                   cache_we,
  output logic [ADDR_WIDTH-1:0]  cache_addr,
  output logic [DATA_WIDTH-1:0]  cache_w_data,
  input  logic [DATA_WIDTH-1:0]  cache_r_data,
  input  logic                   cache_hit,
  output logic                   fill_en,
  output logic [ADDR_WIDTH-1:0]  fill_addr,
  output logic [LINE_SIZE*8-1:0] fill_data,
  output logic                   fill_mark_valid,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_w_data,
  input  logic                   mem_ack,
  input  logic [DATA_WIDTH-1:0]  mem_r_data,
  output logic [CNT_WIDTH-1:0]   hit_count,
  output logic [CNT_WIDTH-1:0]   miss_count
);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [CNT_WIDTH-1:0]    hit_r;
  logic [CNT_WIDTH-1:0]    miss_r;
  // Set for the one IDLE cycle that follows INSTALL, when the stalled read
  // is replayed as a hit that must not be counted.
  logic                    replay_r;

  logic                    latch_miss_s;
  logic                    latch_wr_s;
  logic                    hit_inc_s;
  logic                    miss_inc_s;
  logic                    buf_clear_s;
  logic                    buf_load_s;
  logic [WORD_SEL_BITS-1:0] word_sel_s;
  logic                    buf_last_s;

  l1_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_buffer (
    .clk      (clk),
    .rst      (rst),
    .clear    (buf_clear_s),
    .load     (buf_load_s),
    .data     (mem_r_data),
    .word_sel (word_sel_s),
    .line     (fill_data),
    .last     (buf_last_s)
  );

  assign cache_addr      = cpu_addr;
  assign cache_w_data    = cpu_w_data;
  assign cpu_r_data      = cache_r_data;
  assign fill_addr       = addr_r;
  assign fill_mark_valid = fill_en;
  assign hit_count       = hit_r;
  assign miss_count      = miss_r;

  // State register, request latches, replay flag and performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      wdata_r  <= {DATA_WIDTH{1'b0}};
      hit_r    <= {CNT_WIDTH{1'b0}};
      miss_r   <= {CNT_WIDTH{1'b0}};
      replay_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      replay_r <= (state_r == INSTALL);
      if (latch_miss_s) begin
        addr_r <= {cpu_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      end else if (latch_wr_s) begin
        addr_r  <= cpu_addr;
        wdata_r <= cpu_w_data;
      end
      if (hit_inc_s) begin
        hit_r <= hit_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (miss_inc_s) begin
        miss_r <= miss_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt_s  = state_r;
    cpu_stall    = 1'b0;
    cache_valid  = 1'b0;
    cache_we     = 1'b0;
    fill_en      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {ADDR_WIDTH{1'b0}};
    mem_w_data   = {DATA_WIDTH{1'b0}};
    latch_miss_s = 1'b0;
    latch_wr_s   = 1'b0;
    hit_inc_s    = 1'b0;
    miss_inc_s   = 1'b0;
    buf_clear_s  = 1'b0;
    buf_load_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (cpu_valid && !cpu_we) begin
          cache_valid = 1'b1;
          if (cache_hit) begin
            hit_inc_s = !replay_r;
          end else begin
            cpu_stall    = 1'b1;
            latch_miss_s = 1'b1;
            miss_inc_s   = 1'b1;
            buf_clear_s  = 1'b1;
            state_nxt_s  = FILL;
          end
        end else if (cpu_valid) begin
          // Writes go to memory first; the cache is only touched on the ack.
          cpu_stall   = 1'b1;
          latch_wr_s  = 1'b1;
          state_nxt_s = WRITE;
        end else begin
          cpu_stall = 1'b0;
        end
      end

      WRITE: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = addr_r;
        mem_w_data = wdata_r;
        if (mem_ack) begin
          cache_valid = 1'b1;
          cache_we    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          cpu_stall = 1'b1;
        end
      end

      FILL: begin
        cpu_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {addr_r[ADDR_WIDTH-1:OFFSET_BITS], word_sel_s, {BYTE_SEL_BITS{1'b0}}};
        if (mem_ack) begin
          buf_load_s = 1'b1;
          if (buf_last_s) begin
            state_nxt_s = INSTALL;
          end else begin
            state_nxt_s = FILL;
          end
        end else begin
          buf_load_s = 1'b0;
        end
      end

      INSTALL: begin
        cpu_stall   = 1'b1;
        fill_en     = 1'b1;
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// tb_l1_cache_ctrl
//   Directed and randomized bench for l1_cache_ctrl. The bench plays the
//   part of the cache and of main memory, and predicts results from a
//   transaction-level model: memory contents, the set of cached lines, and
//   hit/miss counts (counters built 4 bits wide so wrap is reachable).
module tb_l1_cache_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_valid, cpu_we;
  logic [31:0]   cpu_addr, cpu_w_data, cpu_r_data;
  logic          cpu_stall;
  logic          cache_valid, cache_we, cache_hit;
  logic [31:0]   cache_addr, cache_w_data, cache_r_data;
  logic          fill_en, fill_mark_valid;
  logic [31:0]   fill_addr;
  logic [127:0]  fill_data;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr, mem_w_data, mem_r_data;
  logic [CW-1:0] hit_count, miss_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1_cache_ctrl #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .LINE_SIZE (16), .CNT_WIDTH (CW)
  ) dut (
    .clk (clk), .rst (rst),
    .cpu_valid (cpu_valid), .cpu_we (cpu_we), .cpu_addr (cpu_addr),
    .cpu_w_data (cpu_w_data), .cpu_r_data (cpu_r_data), .cpu_stall (cpu_stall),
    .cache_valid (cache_valid), .cache_we (cache_we), .cache_addr (cache_addr),
    .cache_w_data (cache_w_data), .cache_r_data (cache_r_data), .cache_hit (cache_hit),
    .fill_en (fill_en), .fill_addr (fill_addr), .fill_data (fill_data),
    .fill_mark_valid (fill_mark_valid),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_w_data (mem_w_data), .mem_ack (mem_ack), .mem_r_data (mem_r_data),
    .hit_count (hit_count), .miss_count (miss_count)
  );

  // Initial memory image: 0x100..0x10C hold 0xA0..0xA3, elsewhere a tag.
  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a >= 32'h0000_0100 && a < 32'h0000_0110) begin
      pat = 32'h0000_00A0 + 32'(a[3:2]);
    end else begin
      pat = {16'hC0DE, a[15:0]};
    end
  endfunction

  // ---------------- memory and cache environment ----------------
  int           mem_wait = 0;
  int           wait_cnt;
  logic [31:0]  mem_arr [0:16383];
  bit           mem_wr  [0:16383];
  logic [127:0] env_line [0:4095];
  bit           env_v    [0:4095];
  logic [127:0] cur_line;
  int           evict_idx = 0;
  int           evict_seq = 0;
  int           evict_seen = 0;

  assign mem_ack      = mem_req && (wait_cnt >= mem_wait);
  assign mem_r_data   = mem_wr[mem_addr[15:2]] ? mem_arr[mem_addr[15:2]] : pat(mem_addr);
  assign cache_hit    = env_v[cache_addr[15:4]];
  assign cur_line     = env_line[cache_addr[15:4]];
  assign cache_r_data = cur_line[cache_addr[3:2]*32 +: 32];

  // Memory wait-state counter.
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Memory writes, line installs, cache write updates and evictions.
  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we) begin
      mem_arr[mem_addr[15:2]] <= mem_w_data;
      mem_wr[mem_addr[15:2]]  <= 1'b1;
    end
    if (fill_en) begin
      env_line[fill_addr[15:4]] <= fill_data;
      env_v[fill_addr[15:4]]    <= 1'b1;
    end
    if (cache_valid && cache_we && env_v[cache_addr[15:4]]) begin
      env_line[cache_addr[15:4]][cache_addr[3:2]*32 +: 32] <= cache_w_data;
    end
    if (evict_seq != evict_seen) begin
      env_v[evict_idx] <= 1'b0;
      evict_seen <= evict_seq;
    end
  end

  // ---------------- monitors ----------------
  int           fill_cnt = 0, cwe_cnt = 0, mreq_cnt = 0, mrd_cnt = 0;
  int           unstable_cnt = 0, fmv_bad = 0;
  logic [31:0]  last_fill_addr = 32'h0;
  logic [127:0] last_fill_data = 128'h0;
  bit           pend = 1'b0;
  logic [31:0]  pend_addr = 32'h0, pend_wdata = 32'h0;

  // Event counters and memory-request stability observer.
  always @(posedge clk) begin
    if (fill_en === 1'b1) begin
      fill_cnt       <= fill_cnt + 1;
      last_fill_addr <= fill_addr;
      last_fill_data <= fill_data;
    end
    if (fill_mark_valid !== fill_en) fmv_bad <= fmv_bad + 1;
    if (cache_valid && cache_we) cwe_cnt <= cwe_cnt + 1;
    if (mem_req) mreq_cnt <= mreq_cnt + 1;
    if (mem_req && mem_ack && !mem_we) mrd_cnt <= mrd_cnt + 1;
    if (pend && mem_req && (mem_addr !== pend_addr || (mem_we && mem_w_data !== pend_wdata)))
      unstable_cnt <= unstable_cnt + 1;
    pend       <= mem_req && !mem_ack && !rst;
    pend_addr  <= mem_addr;
    pend_wdata <= mem_w_data;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_cached [logic [31:0]];
  int          ref_hits = 0, ref_misses = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) ref_rd = ref_mem[a];
    else ref_rd = pat(a);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int w);
    int cyc, f0, r0, q0;
    bit hit_exp;
    logic [31:0] got;
    mem_wait = w;
    hit_exp  = ref_cached.exists(a >> 4);
    f0 = fill_cnt; r0 = mrd_cnt; q0 = mreq_cnt;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = a; cpu_w_data = $urandom;
    cyc = 0;
    @(negedge clk);
    while (cpu_stall !== 1'b0 && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    got = cpu_r_data;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    if (hit_exp) ref_hits++; else ref_misses++;
    ref_cached[a >> 4] = 1'b1;
    check("rd_timeout", 128'(cyc < 300), 128'(1));
    check($sformatf("rd_data@%0h", a), 128'(got), 128'(ref_rd(a)));
    check($sformatf("rd_latency@%0h", a), 128'(cyc), 128'(hit_exp ? 0 : 6 + 4 * w));
    check("rd_fills", 128'(fill_cnt - f0), 128'(hit_exp ? 0 : 1));
    check("rd_mem_words", 128'(mrd_cnt - r0), 128'(hit_exp ? 0 : 4));
    check("rd_mem_req_cycles", 128'(mreq_cnt - q0), 128'(hit_exp ? 0 : 4 * (w + 1)));
    check("hit_count", 128'(hit_count), 128'(ref_hits % 16));
    check("miss_count", 128'(miss_count), 128'(ref_misses % 16));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int w);
    int cyc, f0, q0, c0, u0;
    mem_wait = w;
    f0 = fill_cnt; q0 = mreq_cnt; c0 = cwe_cnt; u0 = unstable_cnt;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_w_data = d;
    cyc = 0;
    @(negedge clk);
    while (cpu_stall !== 1'b0 && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0; cpu_we = 1'b0;
    ref_mem[a] = d;
    check("wr_timeout", 128'(cyc < 300), 128'(1));
    check($sformatf("wr_latency@%0h", a), 128'(cyc), 128'(1 + w));
    check("wr_mem_req_cycles", 128'(mreq_cnt - q0), 128'(1 + w));
    check("wr_cache_we_pulses", 128'(cwe_cnt - c0), 128'(1));
    check("wr_no_fill", 128'(fill_cnt - f0), 128'(0));
    check("wr_mem_stable", 128'(unstable_cnt - u0), 128'(0));
    check("wr_mem_value", 128'(mem_arr[a[15:2]]), 128'(d));
    check("wr_hit_count", 128'(hit_count), 128'(ref_hits % 16));
    check("wr_miss_count", 128'(miss_count), 128'(ref_misses % 16));
  endtask

  task automatic pulse_reset();
    cpu_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ref_hits = 0; ref_misses = 0;
  endtask

  initial begin
    int f0, r0;
    logic [31:0] a;
    rst = 1'b1; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_w_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 128'(cpu_stall), 128'(0));
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_fill_en", 128'(fill_en), 128'(0));
    check("rst_hit_count", 128'(hit_count), 128'(0));
    check("rst_miss_count", 128'(miss_count), 128'(0));
    check("rst_fill_addr", 128'(fill_addr), 128'(0));
    check("rst_fill_data", fill_data, 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Cold read miss with zero-wait memory, then a hit in the same line.
    do_read(32'h0000_0100, 0);
    check("t1_fill_addr", 128'(last_fill_addr), 128'(32'h0000_0100));
    check("t1_fill_data", last_fill_data, 128'h0000_00A3_0000_00A2_0000_00A1_0000_00A0);
    do_read(32'h0000_0104, 0);

    // Write hit with a 2-cycle ack delay, then read it back.
    do_write(32'h0000_0108, 32'h0000_DEAD, 2);
    do_read(32'h0000_0108, 0);

    // Write miss: no allocation, the next read misses and sees the data.
    f0 = fill_cnt;
    do_write(32'h0000_0800, 32'h1234_5678, 1);
    check("wmiss_no_fill", 128'(fill_cnt - f0), 128'(0));
    do_read(32'h0000_0800, 0);

    // Reset after the second fill word of a miss abandons the fill.
    mem_wait = 0;
    f0 = fill_cnt; r0 = mrd_cnt;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_words_before_rst", 128'(mrd_cnt - r0), 128'(2));
    cpu_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_mem_req", 128'(mem_req), 128'(0));
    check("abort_idle_stall", 128'(cpu_stall), 128'(0));
    check("abort_miss_count", 128'(miss_count), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    ref_hits = 0; ref_misses = 0;
    check("abort_no_fill", 128'(fill_cnt - f0), 128'(0));
    do_read(32'h0000_0200, 0);

    // Sixteen cold misses wrap the 4-bit miss counter back to zero.
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      do_read(32'h0000_4000 + 32'(i * 16), 0);
    end
    check("wrap_miss_count", 128'(miss_count), 128'(0));

    // Randomized mix of reads, writes, wait states and evictions.
    for (int n = 0; n < 80; n++) begin
      a = 32'h0000_1000 + 32'($urandom_range(0, 7) << 4) + 32'($urandom_range(0, 3) << 2);
      if ($urandom_range(0, 9) == 0) begin
        evict_idx = int'(a >> 4);
        evict_seq = evict_seq + 1;
        ref_cached.delete(a >> 4);
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 2) == 0) do_write(a, $urandom, $urandom_range(0, 2));
      else do_read(a, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    check("fill_mark_valid_tracks_fill_en", 128'(fmv_bad), 128'(0));
    check("mem_addr_stable_overall", 128'(unstable_cnt), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
